// File: rtl/s2p_pkg.sv
// Shared constants and sizing helpers for the serial2parallel deserializer.
// S2P_PARITY_EN appends one even-parity bit to every serial frame.
package s2p_pkg;

    localparam int S2P_DEF_WIDTH = 4;

`ifdef S2P_PARITY_EN
    localparam int S2P_PAR_BITS = 1;
`else
    localparam int S2P_PAR_BITS = 0;
`endif

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Number of serial bits per word, including the optional parity bit.
    function automatic int frame_len(input int width);
        return width + S2P_PAR_BITS;
    endfunction

endpackage

// File: rtl/s2p_hold_reg.sv
// One-deep valid/ready holding register with a sticky overflow flag.
// A completion that finds the register full and not draining is dropped.
module s2p_hold_reg
    import s2p_pkg::*;
#(
    parameter int DATA_W = S2P_DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    input  logic              i_ovf_clr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_ovf
);

    logic w_take;

    assign w_take = i_load && (!o_valid || i_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            if (w_take) begin
                o_data  <= i_data;
                o_valid <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            // A new overflow beats a simultaneous clear.
            if (i_load && !w_take) begin
                o_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                o_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial2parallel.sv
// MSB-first serial-to-parallel deserializer with a valid/ready output stage.
// S2P_PARITY_EN adds a trailing even-parity bit per word and the par_err port.
module serial2parallel
    import s2p_pkg::*;
#(
    parameter int WIDTH = S2P_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             ovf,
    input  logic             ovf_clr
`ifdef S2P_PARITY_EN
    ,
    output logic             par_err
`endif
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int CW    = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_cnt;
    logic             w_last;

    assign w_last = din_valid && !sof && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (din_valid) begin
            if (sof) begin
                r_sreg <= {{(WIDTH-1){1'b0}}, din};
                r_cnt  <= CW'(1);
            end else begin
                r_sreg <= {r_sreg[WIDTH-2:0], din};
                r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

`ifdef S2P_PARITY_EN
    // On the parity bit the data already sits in r_sreg; din is the parity bit.
    localparam int HW = WIDTH + 1;
    logic [HW-1:0] w_hold_in;
    logic [HW-1:0] w_hold_out;

    assign w_hold_in = {(^r_sreg) ^ din, r_sreg};
    assign dout      = w_hold_out[WIDTH-1:0];
    assign par_err   = w_hold_out[WIDTH];
`else
    localparam int HW = WIDTH;
    logic [HW-1:0] w_hold_in;
    logic [HW-1:0] w_hold_out;
    logic          w_unused_msb;

    assign w_hold_in    = {r_sreg[WIDTH-2:0], din};
    assign dout         = w_hold_out;
    assign w_unused_msb = r_sreg[WIDTH-1];
`endif

    s2p_hold_reg #(
        .DATA_W (HW)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_last),
        .i_data    (w_hold_in),
        .i_ready   (ready_in),
        .i_ovf_clr (ovf_clr),
        .o_data    (w_hold_out),
        .o_valid   (valid_out),
        .o_ovf     (ovf)
    );

endmodule

// File: tb/tb_serial2parallel.sv
// Self-checking bench for serial2parallel (WIDTH=4); parity cases build with S2P_PARITY_EN.
module tb_serial2parallel;

    localparam int W = 4;
`ifdef S2P_PARITY_EN
    localparam int FR = W + 1;
`else
    localparam int FR = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         din;
    logic         din_valid;
    logic         sof;
    logic         ready_in;
    logic         ovf_clr;
    logic [W-1:0] dout;
    logic         valid_out;
    logic         ovf;
`ifdef S2P_PARITY_EN
    logic         par_err;
`endif

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] exp_w;

    always #5 clk = ~clk;

    serial2parallel #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .sof       (sof),
        .dout      (dout),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`ifdef S2P_PARITY_EN
        ,
        .par_err   (par_err)
`endif
    );

    // Bit j of the serial frame for word w (trailing even parity when enabled).
    function automatic logic fbit(input logic [W-1:0] w, input int j);
        if (j < W) return w[W-1-j];
        return ^w;
    endfunction

    task automatic bit_in(input logic v, input logic s, input logic d);
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sof       = 1'b0;
        din       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) bit_in(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int j = 0; j < FR; j++) bit_in(1'b1, j == 0, fbit(w, j));
    endtask

    task automatic test_reset;
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; sof = 1'b0;
        ready_in = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %b want 0", dout); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_single;
        ready_in = 1'b1;
        q.push_back(4'b1011);
        send_word(4'b1011);
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", valid_out); end
        exp_w = q.pop_front();
        checks++; if (dout !== exp_w) begin errors++; $display("FAIL single_dout: got %b want %b", dout, exp_w); end
        idle(1);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", valid_out); end
        checks++; if (dout !== 4'b1011) begin errors++; $display("FAIL single_dout_hold: got %b want 1011", dout); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] words [2];
        words[0] = 4'b1011;
        words[1] = 4'b0110;
        ready_in = 1'b1;
        for (int wi = 0; wi < 2; wi++) begin
            q.push_back(words[wi]);
            for (int j = 0; j < FR; j++) begin
                bit_in(1'b1, j == 0, fbit(words[wi], j));
                checks++;
                if (valid_out !== (j == FR - 1)) begin
                    errors++; $display("FAIL b2b_valid w%0d b%0d: got %b want %b", wi, j, valid_out, j == FR - 1);
                end
                if (j == FR - 1) begin
                    exp_w = q.pop_front();
                    checks++; if (dout !== exp_w) begin errors++; $display("FAIL b2b_dout w%0d: got %b want %b", wi, dout, exp_w); end
                end
            end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
        idle(1);
    endtask

    task automatic test_overflow;
        ready_in = 1'b0;
        q.push_back(4'b1011);
        send_word(4'b1011);
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL ovf_first_valid: got %b want 1", valid_out); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", ovf); end
        send_word(4'b0001);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
        checks++; if (dout !== q[0]) begin errors++; $display("FAIL ovf_dout_kept: got %b want %b", dout, q[0]); end
        ready_in = 1'b1;
        exp_w = q.pop_front();
        checks++; if (dout !== exp_w) begin errors++; $display("FAIL ovf_accept_dout: got %b want %b", dout, exp_w); end
        idle(1);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL ovf_accept_valid: got %b want 0", valid_out); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf); end
        // Clear coinciding with a new overflow leaves the flag set.
        ready_in = 1'b0;
        q.push_back(4'b0110);
        send_word(4'b0110);
        for (int j = 0; j < FR - 1; j++) bit_in(1'b1, j == 0, fbit(4'b1111, j));
        ovf_clr = 1'b1;
        bit_in(1'b1, 1'b0, fbit(4'b1111, FR - 1));
        ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b want 1", ovf); end
        ready_in = 1'b1;
        exp_w = q.pop_front();
        checks++; if (dout !== exp_w) begin errors++; $display("FAIL ovf_drain_dout: got %b want %b", dout, exp_w); end
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL ovf_drain_valid: got %b want 0", valid_out); end
    endtask

    task automatic test_sof_restart;
        ready_in = 1'b1;
        bit_in(1'b1, 1'b1, 1'b1);
        bit_in(1'b1, 1'b0, 1'b0);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL sof_partial_valid: got %b want 0", valid_out); end
        q.push_back(4'b1100);
        send_word(4'b1100);
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL sof_valid: got %b want 1", valid_out); end
        exp_w = q.pop_front();
        checks++; if (dout !== exp_w) begin errors++; $display("FAIL sof_dout: got %b want %b", dout, exp_w); end
        idle(1);
    endtask

    task automatic test_gaps_reset;
        ready_in = 1'b1;
        q.push_back(4'b1011);
        for (int j = 0; j < FR; j++) begin
            idle(1 + (j % 2));
            bit_in(1'b1, j == 0, fbit(4'b1011, j));
        end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b want 1", valid_out); end
        exp_w = q.pop_front();
        checks++; if (dout !== exp_w) begin errors++; $display("FAIL gap_dout: got %b want %b", dout, exp_w); end
        idle(1);
        // Held word, overflow and a partial word all in flight when reset hits.
        ready_in = 1'b0;
        send_word(4'b0111);
        send_word(4'b0010);
        bit_in(1'b1, 1'b1, 1'b1);
        bit_in(1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (dout !== '0) begin errors++; $display("FAIL rst_mid_dout: got %b want 0", dout); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", valid_out); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf: got %b want 0", ovf); end
        @(posedge clk);
        #1 rst = 1'b0;
        ready_in = 1'b1;
        // Counter restarts at zero, so a frame without sof still aligns.
        q.push_back(4'b0101);
        for (int j = 0; j < FR; j++) bit_in(1'b1, 1'b0, fbit(4'b0101, j));
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL rst_nosof_valid: got %b want 1", valid_out); end
        exp_w = q.pop_front();
        checks++; if (dout !== exp_w) begin errors++; $display("FAIL rst_nosof_dout: got %b want %b", dout, exp_w); end
        q.push_back(4'b1011);
        send_word(4'b1011);
        exp_w = q.pop_front();
        checks++; if (dout !== exp_w) begin errors++; $display("FAIL rst_after_dout: got %b want %b", dout, exp_w); end
        idle(1);
    endtask

`ifdef S2P_PARITY_EN
    task automatic send_word_p(input logic [W-1:0] w, input logic p);
        for (int j = 0; j < W; j++) bit_in(1'b1, j == 0, w[W-1-j]);
        bit_in(1'b1, 1'b0, p);
    endtask

    task automatic test_parity;
        ready_in = 1'b1;
        send_word_p(4'b1011, 1'b1);
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_good: got %b want 0", par_err); end
        checks++; if (dout !== 4'b1011) begin errors++; $display("FAIL par_good_dout: got %b want 1011", dout); end
        send_word_p(4'b1011, 1'b0);
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_bad: got %b want 1", par_err); end
        idle(1);
        ready_in = 1'b0;
        send_word_p(4'b0011, 1'b0);
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_held: got %b want 0", par_err); end
        send_word_p(4'b0001, 1'b0);
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_drop: got %b want 0", par_err); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL par_drop_ovf: got %b want 1", ovf); end
        ready_in = 1'b1;
        ovf_clr  = 1'b1;
        idle(1);
        ovf_clr  = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_sof_restart();
        test_gaps_reset();
`ifdef S2P_PARITY_EN
        test_parity();
`endif
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d pending want 0", q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
